// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with synchronous clear and occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   n_rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             full;

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == (PW+1)'(DEPTH));
  end

  // A pop frees the slot in the same cycle, so push on full is legal only alongside it.
  a_no_overflow:  assert property (@(posedge clk_i) disable iff (!n_rst) !(push && full && !pop && !clr));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!n_rst) !(pop && empty && !clr));

endmodule

// File: rtl/fetch_frontend.sv
// PC owner and prefetch queue feeding IF/ID from a fixed-latency instruction memory.
module fetch_frontend #(
  parameter int unsigned     XLEN        = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(fetch_pkg::DEFAULT_RESET_PC),
  parameter int unsigned     DEPTH       = 4,
  parameter int unsigned     MEM_LATENCY = 1
) (
  input  logic            clk_i,
  input  logic            n_rst,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            flush_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = 32 + XLEN;

  logic [XLEN-1:0]             pc_q;
  logic [MEM_LATENCY-1:0]      stage_v_q;
  logic [MEM_LATENCY*XLEN-1:0] stage_pc_q;
  logic                        flush_q;
  logic [CW-1:0]               fifo_count;
  logic [CW-1:0]               inflight;
  logic [CW:0]                 occupancy;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  logic [EW-1:0]               wdata;
  logic [EW-1:0]               head;

  // Credits count queued plus in-flight entries so a returning response always has a slot.
  always_comb begin
    inflight   = CW'($countones(stage_v_q));
    occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    imem_req_o = n_rst && !redirect_en_i && (occupancy < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      pc_q       <= RESET_PC;
      stage_v_q  <= '0;
      stage_pc_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      flush_q    <= redirect_en_i;
      stage_pc_q <= (MEM_LATENCY*XLEN)'({stage_pc_q, pc_q});
      if (redirect_en_i) begin
        stage_v_q <= '0;
        pc_q      <= redirect_pc_i & ~XLEN'(3);
      end else begin
        stage_v_q <= MEM_LATENCY'({stage_v_q, imem_req_o});
        if (imem_req_o) begin
          pc_q <= pc_q + XLEN'(4);
        end
      end
    end
  end

  always_comb begin
    push         = stage_v_q[MEM_LATENCY-1] && !redirect_en_i;
    pop          = inst_valid_o && inst_ready_i;
    wdata        = {imem_rdata_i, stage_pc_q[MEM_LATENCY*XLEN-1 -: XLEN]};
    inst_valid_o = !fifo_empty;
    inst_o       = head[EW-1 -: 32];
    inst_pc_o    = head[XLEN-1:0];
    imem_addr_o  = pc_q;
    flush_o      = flush_q;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_queue (
    .clk_i (clk_i),
    .n_rst (n_rst),
    .clr   (redirect_en_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_frontend.sv
// Directed bench for fetch_frontend at MEM_LATENCY 1 and 3; memory returns ~addr.
module tb_fetch_frontend;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;

  logic        redir1 = 1'b0, redir3 = 1'b0;
  logic [31:0] rpc1 = '0, rpc3 = '0;
  logic        req1, req3;
  logic [31:0] addr1, addr3;
  logic [31:0] rdata1, rdata3;
  logic        valid1, valid3;
  logic        ready1 = 1'b1, ready3 = 1'b1;
  logic [31:0] inst1, inst3;
  logic [31:0] ipc1, ipc3;
  logic        flush1, flush3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  logic [31:0] m1_q;
  logic [31:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= addr1;
    m3_q[0] <= addr3;
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rdata1 = ~m1_q;
  assign rdata3 = ~m3_q[2];

  fetch_frontend #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4), .MEM_LATENCY(1)) dut1 (
    .clk_i(clk), .n_rst(n_rst), .redirect_en_i(redir1), .redirect_pc_i(rpc1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_rdata_i(rdata1),
    .inst_valid_o(valid1), .inst_ready_i(ready1), .inst_o(inst1),
    .inst_pc_o(ipc1), .flush_o(flush1));

  fetch_frontend #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4), .MEM_LATENCY(3)) dut3 (
    .clk_i(clk), .n_rst(n_rst), .redirect_en_i(redir3), .redirect_pc_i(rpc3),
    .imem_req_o(req3), .imem_addr_o(addr3), .imem_rdata_i(rdata3),
    .inst_valid_o(valid3), .inst_ready_i(ready3), .inst_o(inst3),
    .inst_pc_o(ipc3), .flush_o(flush3));

  task automatic test_reset();
    @(negedge clk); #1;
    vectors++; if (req1 !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b exp 0", req1); end
    vectors++; if (valid1 !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b exp 0", valid1); end
    vectors++; if (flush1 !== 1'b0) begin miscompares++; $display("FAIL rst_flush: got %b exp 0", flush1); end
    vectors++; if (inst1 !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h exp 0", inst1); end
    vectors++; if (ipc1 !== 32'h0) begin miscompares++; $display("FAIL rst_ipc: got %h exp 0", ipc1); end
    vectors++; if (addr1 !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h exp 0", addr1); end
    vectors++; if (req3 !== 1'b0) begin miscompares++; $display("FAIL rst_req3: got %b exp 0", req3); end
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    n_rst = 1'b1; #1;
    vectors++; if (req1 !== 1'b1 || addr1 !== 32'h0) begin miscompares++; $display("FAIL seq_first_req: got %b/%h exp 1/0", req1, addr1); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      e = 32'(4 * k);
      vectors++; if (req1 !== 1'b1 || addr1 !== e) begin miscompares++; $display("FAIL seq_req c%0d: got %b/%h exp 1/%h", k, req1, addr1, e); end
      vectors++; if (valid1 !== (k >= 2)) begin miscompares++; $display("FAIL seq_valid c%0d: got %b exp %b", k, valid1, (k >= 2)); end
      if (k >= 2) begin
        e = 32'(4 * (k - 2));
        vectors++; if (ipc1 !== e || inst1 !== ~e) begin miscompares++; $display("FAIL seq_head c%0d: got %h/%h exp %h/%h", k, ipc1, inst1, e, ~e); end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    @(negedge clk); ready1 = 1'b0;
    #1 n_rst = 1'b0;
    #1 n_rst = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      vectors++; if (req1 !== (k < 4)) begin miscompares++; $display("FAIL stall_req c%0d: got %b exp %b", k, req1, (k < 4)); end
    end
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h0 || addr1 !== 32'h10) begin miscompares++; $display("FAIL stall_hold: got %b/%h/%h exp 1/0/10", valid1, ipc1, addr1); end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      ready1 = 1'b1;
      #1;
      e = 32'(4 * j);
      vectors++; if (valid1 !== 1'b1 || ipc1 !== e || inst1 !== ~e) begin miscompares++; $display("FAIL stall_drain j%0d: got %b/%h/%h exp 1/%h/%h", j, valid1, ipc1, inst1, e, ~e); end
      if (j == 0) begin
        vectors++; if (req1 !== 1'b0) begin miscompares++; $display("FAIL stall_noreq: got %b exp 0", req1); end
      end
      if (j == 1) begin
        vectors++; if (req1 !== 1'b1 || addr1 !== 32'h10) begin miscompares++; $display("FAIL stall_resume: got %b/%h exp 1/10", req1, addr1); end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    @(negedge clk);
    #1 n_rst = 1'b0;
    #1 n_rst = 1'b1;
    #1;
    vectors++; if (req3 !== 1'b1 || addr3 !== 32'h0) begin miscompares++; $display("FAIL rdi_req0: got %b/%h exp 1/0", req3, addr3); end
    @(negedge clk); #1;
    vectors++; if (req3 !== 1'b1 || addr3 !== 32'h4) begin miscompares++; $display("FAIL rdi_req1: got %b/%h exp 1/4", req3, addr3); end
    @(negedge clk); redir3 = 1'b1; rpc3 = 32'h100; #1;
    vectors++; if (req3 !== 1'b0) begin miscompares++; $display("FAIL rdi_noreq: got %b exp 0", req3); end
    @(negedge clk); redir3 = 1'b0; #1;
    vectors++; if (flush3 !== 1'b1 || req3 !== 1'b1 || addr3 !== 32'h100 || valid3 !== 1'b0) begin miscompares++; $display("FAIL rdi_r1: got fl%b req%b %h v%b exp 1 1 100 0", flush3, req3, addr3, valid3); end
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk); #1;
      vectors++; if (flush3 !== 1'b0 || valid3 !== 1'b0) begin miscompares++; $display("FAIL rdi_kill c%0d: got fl%b v%b exp 0 0", k, flush3, valid3); end
    end
    @(negedge clk); #1;
    vectors++; if (valid3 !== 1'b1 || ipc3 !== 32'h100 || inst3 !== 32'hFFFF_FEFF) begin miscompares++; $display("FAIL rdi_head0: got %b/%h/%h exp 1/100/fffffeff", valid3, ipc3, inst3); end
    @(negedge clk); #1;
    vectors++; if (valid3 !== 1'b1 || ipc3 !== 32'h104 || inst3 !== 32'hFFFF_FEFB) begin miscompares++; $display("FAIL rdi_head1: got %b/%h/%h exp 1/104/fffffefb", valid3, ipc3, inst3); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); redir1 = 1'b1; rpc1 = 32'h203; #1;
    vectors++; if (req1 !== 1'b0) begin miscompares++; $display("FAIL mis_noreq: got %b exp 0", req1); end
    @(negedge clk); redir1 = 1'b0; #1;
    vectors++; if (addr1 !== 32'h200 || req1 !== 1'b1 || flush1 !== 1'b1 || valid1 !== 1'b0) begin miscompares++; $display("FAIL mis_addr: got %h req%b fl%b v%b exp 200 1 1 0", addr1, req1, flush1, valid1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b0 || flush1 !== 1'b0) begin miscompares++; $display("FAIL mis_gap: got v%b fl%b exp 0 0", valid1, flush1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h200 || inst1 !== 32'hFFFF_FDFF) begin miscompares++; $display("FAIL mis_head: got %b/%h/%h exp 1/200/fffffdff", valid1, ipc1, inst1); end
  endtask

  task automatic test_full_redirect();
    @(negedge clk); ready1 = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    vectors++; if (valid1 !== 1'b1 || req1 !== 1'b0) begin miscompares++; $display("FAIL full_state: got v%b req%b exp 1 0", valid1, req1); end
    @(negedge clk); ready1 = 1'b1; redir1 = 1'b1; rpc1 = 32'h40; #1;
    vectors++; if (valid1 !== 1'b1 || req1 !== 1'b0) begin miscompares++; $display("FAIL full_popcycle: got v%b req%b exp 1 0", valid1, req1); end
    @(negedge clk); redir1 = 1'b0; #1;
    vectors++; if (valid1 !== 1'b0 || flush1 !== 1'b1) begin miscompares++; $display("FAIL full_cleared: got v%b fl%b exp 0 1", valid1, flush1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b0 || flush1 !== 1'b0) begin miscompares++; $display("FAIL full_nopush: got v%b fl%b exp 0 0", valid1, flush1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h40 || inst1 !== 32'hFFFF_FFBF) begin miscompares++; $display("FAIL full_head: got %b/%h/%h exp 1/40/ffffffbf", valid1, ipc1, inst1); end
  endtask

  task automatic test_wrap();
    @(negedge clk); redir1 = 1'b1; rpc1 = 32'hFFFF_FFFC; #1;
    @(negedge clk); redir1 = 1'b0; #1;
    vectors++; if (req1 !== 1'b1 || addr1 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top: got %b/%h exp 1/fffffffc", req1, addr1); end
    @(negedge clk); #1;
    vectors++; if (req1 !== 1'b1 || addr1 !== 32'h0) begin miscompares++; $display("FAIL wrap_zero: got %b/%h exp 1/0", req1, addr1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'hFFFF_FFFC || inst1 !== 32'h3) begin miscompares++; $display("FAIL wrap_head0: got %b/%h/%h exp 1/fffffffc/3", valid1, ipc1, inst1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h0 || inst1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_head1: got %b/%h/%h exp 1/0/ffffffff", valid1, ipc1, inst1); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); redir1 = 1'b1; rpc1 = 32'h300; #1;
    vectors++; if (req1 !== 1'b0) begin miscompares++; $display("FAIL b2b_noreq0: got %b exp 0", req1); end
    @(negedge clk); rpc1 = 32'h400; #1;
    vectors++; if (flush1 !== 1'b1 || req1 !== 1'b0) begin miscompares++; $display("FAIL b2b_second: got fl%b req%b exp 1 0", flush1, req1); end
    @(negedge clk); redir1 = 1'b0; #1;
    vectors++; if (flush1 !== 1'b1 || req1 !== 1'b1 || addr1 !== 32'h400 || valid1 !== 1'b0) begin miscompares++; $display("FAIL b2b_after: got fl%b req%b %h v%b exp 1 1 400 0", flush1, req1, addr1, valid1); end
    @(negedge clk); #1;
    vectors++; if (flush1 !== 1'b0 || valid1 !== 1'b0) begin miscompares++; $display("FAIL b2b_end: got fl%b v%b exp 0 0", flush1, valid1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h400 || inst1 !== 32'hFFFF_FBFF) begin miscompares++; $display("FAIL b2b_head: got %b/%h/%h exp 1/400/fffffbff", valid1, ipc1, inst1); end
  endtask

  task automatic test_reset_midstream();
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (valid1 !== 1'b1) begin miscompares++; $display("FAIL mrst_live: got %b exp 1", valid1); end
    n_rst = 1'b0;
    #1;
    vectors++; if (req1 !== 1'b0 || valid1 !== 1'b0 || flush1 !== 1'b0) begin miscompares++; $display("FAIL mrst_ctl: got req%b v%b fl%b exp 0 0 0", req1, valid1, flush1); end
    vectors++; if (inst1 !== 32'h0 || ipc1 !== 32'h0 || addr1 !== 32'h0) begin miscompares++; $display("FAIL mrst_data: got %h/%h/%h exp 0/0/0", inst1, ipc1, addr1); end
    n_rst = 1'b1;
    #1;
    vectors++; if (req1 !== 1'b1 || addr1 !== 32'h0) begin miscompares++; $display("FAIL mrst_req0: got %b/%h exp 1/0", req1, addr1); end
    @(negedge clk); #1;
    vectors++; if (addr1 !== 32'h4 || valid1 !== 1'b0) begin miscompares++; $display("FAIL mrst_req1: got %h v%b exp 4 0", addr1, valid1); end
    @(negedge clk); #1;
    vectors++; if (valid1 !== 1'b1 || ipc1 !== 32'h0 || inst1 !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mrst_head: got %b/%h/%h exp 1/0/ffffffff", valid1, ipc1, inst1); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_inflight();
    test_misaligned();
    test_full_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_frontend.md
Name: fetch_frontend

Overview:
- Parametrised successor to the single-register fetch path.
- Owns the PC register and issues sequential requests to a fixed-latency instruction memory.
- Buffers returned instructions in a DEPTH-entry prefetch queue and presents them to the IF/ID register with a valid/ready handshake.
- Handles branch/jump redirects from EX: kills in-flight requests, clears the queue and pulses a flush to IF/ID.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- DEPTH, 4, prefetch queue entries; power of 2, ≥2.
- MEM_LATENCY, 1, fixed cycles from imem_req_o to imem_rdata_i; range 1..4.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- n_rst  in  1  asynchronous active-low reset.
- redirect_en_i  in  1  EX redirect request.
- redirect_pc_i  in  XLEN  redirect target.
- imem_req_o  out  1  instruction read request.
- imem_addr_o  out  XLEN  word address of request; bits [1:0] always 0.
- imem_rdata_i  in  32  read data, valid exactly MEM_LATENCY cycles after the request; memory never backpressures.
- inst_valid_o  out  1  queue head valid.
- inst_ready_i  in  1  IF/ID accepts the head (= !stall).
- inst_o  out  32  head instruction.
- inst_pc_o  out  XLEN  PC of head instruction.
- flush_o  out  1  one-cycle IF/ID flush pulse.

Behaviour:
- Reset (async, n_rst=0) sets:
  - pc = RESET_PC; imem_addr_o = RESET_PC.
  - imem_req_o = 0, inst_valid_o = 0, flush_o = 0.
  - inst_o = 0, inst_pc_o = 0.
  - Queue empty; all in-flight tags cleared.
- Reset asserted mid-operation discards everything immediately. The first request issues RESET_PC on the first edge after deassertion.
- In-flight tracking:
  - A shift pipe of MEM_LATENCY stages, each carrying {valid, pc}.
  - Stage 0 loads {imem_req_o, imem_addr_o}.
  - The last stage, when valid, pushes {imem_rdata_i, pc} into the queue.
- Credit rule: imem_req_o = 1 iff (queue count + in-flight count) < DEPTH and redirect_en_i = 0. The queue therefore never overflows.
- PC update:
  - On an issued request: pc <= pc + 4, modulo 2^XLEN, so 0xFFFF_FFFC wraps to 0.
  - With no request: pc holds.
- Redirect cycle (redirect_en_i = 1):
  - pc <= {redirect_pc_i[XLEN-1:2], 2'b00}; misaligned low bits are ignored.
  - All in-flight valid bits are cleared, so killed responses are dropped.
  - The queue is cleared and no request is issued in that cycle.
  - flush_o = 1 on the following cycle only.
- Redirect takes priority over push, pop and request. A head transfer in the redirect cycle still completes; flush_o removes it from IF/ID.
- Back-to-back redirects: the last one wins; flush_o stays high one cycle after each.
- Output and queue:
  - inst_valid_o = (queue count ≠ 0); inst_o and inst_pc_o are the queue head, don't-care when invalid.
  - Pop on inst_valid_o & inst_ready_i.
  - Simultaneous push and pop allowed, including when full.
  - Pop on empty and push on full cannot occur by construction; assert on both in simulation.
- Latency:
  - Request at cycle T → data pushed at the edge ending cycle T+MEM_LATENCY → inst_valid_o high in cycle T+MEM_LATENCY+1.
  - Steady-state throughput: 1 instruction/cycle with inst_ready_i held high.
- Queue pointers: log2(DEPTH) bits, wrapping naturally. Count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - Typedef fetch_entry_t {logic [31:0] inst; logic [XLEN-1:0] pc;}, sized by the package XLEN.
- One sub-module: sync_fifo, parametrised on DEPTH and WIDTH, with synchronous clear, count output and overflow/underflow assertions. Same clock and async reset.

Test Plan:
1. Reset release, MEM_LATENCY=1, ready=1 → requests 0x0, 0x4, 0x8 … on consecutive cycles; inst_valid_o first high 2 cycles after the first request; inst_pc_o sequence 0x0, 0x4, 0x8.
2. inst_ready_i=0 for 10 cycles, DEPTH=4 → at most 4 entries outstanding/buffered, imem_req_o drops to 0, no entry lost; on ready=1, PCs continue 0x0…0xC in order, then requests resume at 0x10.
3. Redirect to 0x100 while 2 requests are in flight, MEM_LATENCY=3 → killed responses never appear; flush_o high exactly one cycle; next inst_pc_o = 0x100, then 0x104.
4. Redirect to 0x203 → imem_addr_o = 0x200.
5. Redirect in the same cycle as a head pop with a full queue → queue empty next cycle, no push from dropped data.
6. pc = 0xFFFF_FFFC → next request addr 0x0000_0000.
7. n_rst pulsed low mid-stream for 1 ns between edges → outputs at reset values immediately; fetch restarts at RESET_PC.
